// File: rtl/adc_stream_pkg.sv
// adc_stream_pkg: shared definitions for the ADC frame streamer.
//   - FSM state encoding (legacy-compatible localparams)
//   - default frame start marker
//   - frame length and index-width helpers
//   - parameter legality check used at elaboration
package adc_stream_pkg;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StCapture  = 3'd1;
  localparam logic [2:0] StLoad     = 3'd2;
  localparam logic [2:0] StSend     = 3'd3;
  localparam logic [2:0] StWaitAck  = 3'd4;
  localparam logic [2:0] StWaitDone = 3'd5;
  localparam logic [2:0] StDone     = 3'd6;

  localparam logic [7:0] DefaultHdrByte = 8'hA5;

  // Header + channel count + 16-bit payload per sample + checksum.
  function automatic int unsigned frame_len(input int unsigned n_ch, input int unsigned depth);
    return 3 + 2 * depth * n_ch;
  endfunction

  // Width of an index over n items; never zero so single-item ranges stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_legal(input int unsigned n_ch, input int unsigned sample_w,
                                      input int unsigned depth);
    return (n_ch >= 1) && (n_ch <= 8) && (sample_w >= 1) && (sample_w <= 16) &&
           (depth >= 2) && (depth <= 256) && (n_ch * depth <= 32767);
  endfunction

endpackage

// File: rtl/sample_buffer.sv
// sample_buffer: DEPTH x N_CH sample store for one frame.
//   clk_i      system clock
//   we_i       write all channels of wr_data_i into entry wr_set_i
//   wr_set_i   set index being captured
//   wr_data_i  packed raw samples, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   rd_set_i   set index of the byte to read
//   rd_ch_i    channel index of the byte to read
//   rd_half_i  0 = low byte, 1 = high byte of the zero-extended 16-bit sample
//   rd_byte_o  combinational read byte
module sample_buffer
  import adc_stream_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned DEPTH    = 32
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [idx_w(DEPTH)-1:0]    wr_set_i,
  input  logic [N_CH*SAMPLE_W-1:0]   wr_data_i,
  input  logic [idx_w(DEPTH)-1:0]    rd_set_i,
  input  logic [idx_w(N_CH)-1:0]     rd_ch_i,
  input  logic                       rd_half_i,
  output logic [7:0]                 rd_byte_o
);

  localparam int unsigned ChW = idx_w(N_CH);

  // Samples are stored already widened to 16 bits so reads are pure byte selects.
  logic [N_CH*16-1:0] mem_q [DEPTH];
  logic [N_CH*16-1:0] wr_word;
  logic [15:0]        rd_sample;

  always_comb begin
    wr_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      wr_word[k*16 +: 16] = 16'(wr_data_i[k*SAMPLE_W +: SAMPLE_W]);
    end
  end

  // No reset: contents are only read after a full capture has rewritten every entry.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_set_i] <= wr_word;
    end
  end

  always_comb begin
    rd_sample = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ChW'(k) == rd_ch_i) begin
        rd_sample = mem_q[rd_set_i][k*16 +: 16];
      end
    end
  end

  assign rd_byte_o = rd_half_i ? rd_sample[15:8] : rd_sample[7:0];

endmodule

// File: rtl/adc_frame_streamer.sv
// adc_frame_streamer: captures DEPTH sample sets of N_CH ADC channels and streams them as a
// framed byte packet (header, channel count, payload, checksum) through a uart transmitter.
//   sysclk     system clock
//   rst        synchronous active-high reset
//   start      level capture request (checked in idle and done only)
//   mode       0 = single-shot, 1 = continuous (latched when a capture run begins)
//   sample_en  one-cycle sample strobe
//   adc_data   channel k at [k*SAMPLE_W +: SAMPLE_W]
//   tx_busy    uart busy
//   tx_data    byte to uart
//   tx_wr_en   one-cycle uart write pulse
//   ready      frame complete (held in single-shot, pulsed in continuous)
//   busy       high in any state except idle and done
//   overrun    sticky; strobe seen while transmitting in continuous mode
module adc_frame_streamer
  import adc_stream_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned DEPTH    = 32,
  parameter logic [7:0]  HDR_BYTE = DefaultHdrByte
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     sample_en,
  input  logic [N_CH*SAMPLE_W-1:0] adc_data,
  input  logic                     tx_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_wr_en,
  output logic                     ready,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned FrameLen = frame_len(N_CH, DEPTH);
  localparam int unsigned IdxW     = $clog2(FrameLen);
  localparam int unsigned SetW     = idx_w(DEPTH);
  localparam int unsigned ChW      = idx_w(N_CH);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameLen - 1);
  localparam logic [IdxW-1:0] FirstPl = IdxW'(2);
  localparam logic [SetW-1:0] LastSet = SetW'(DEPTH - 1);
  localparam logic [ChW-1:0]  LastCh  = ChW'(N_CH - 1);

  if (!params_legal(N_CH, SAMPLE_W, DEPTH)) begin : gen_bad_params
    $error("adc_frame_streamer: illegal N_CH/SAMPLE_W/DEPTH combination");
  end

  logic [2:0]      state_q, state_d;
  logic [SetW-1:0] set_cnt_q, set_cnt_d;
  logic [IdxW-1:0] byte_idx_q, byte_idx_d;
  logic [SetW-1:0] rd_set_q, rd_set_d;
  logic [ChW-1:0]  rd_ch_q, rd_ch_d;
  logic            rd_half_q, rd_half_d;
  logic [7:0]      cksum_q, cksum_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_wr_en_q, tx_wr_en_d;
  logic            ready_q, ready_d;
  logic            overrun_q, overrun_d;
  logic            mode_q, mode_d;

  logic            buf_we;
  logic [7:0]      buf_byte;
  logic [7:0]      cur_byte;
  logic            xmit_state;

  sample_buffer #(
    .N_CH     (N_CH),
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH)
  ) u_sample_buffer (
    .clk_i     (sysclk),
    .we_i      (buf_we),
    .wr_set_i  (set_cnt_q),
    .wr_data_i (adc_data),
    .rd_set_i  (rd_set_q),
    .rd_ch_i   (rd_ch_q),
    .rd_half_i (rd_half_q),
    .rd_byte_o (buf_byte)
  );

  // Byte at byte_idx_q; payload bytes come from the buffer read pointer, which is
  // stepped in lockstep with byte_idx_q so no divider is needed.
  always_comb begin
    if (byte_idx_q == '0) begin
      cur_byte = HDR_BYTE;
    end else if (byte_idx_q == IdxW'(1)) begin
      cur_byte = 8'(N_CH);
    end else if (byte_idx_q == LastIdx) begin
      cur_byte = cksum_q;
    end else begin
      cur_byte = buf_byte;
    end
  end

  assign xmit_state = (state_q == StLoad) || (state_q == StSend) || (state_q == StWaitAck) ||
                      (state_q == StWaitDone) || (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    set_cnt_d  = set_cnt_q;
    byte_idx_d = byte_idx_q;
    rd_set_d   = rd_set_q;
    rd_ch_d    = rd_ch_q;
    rd_half_d  = rd_half_q;
    cksum_d    = cksum_q;
    tx_data_d  = tx_data_q;
    tx_wr_en_d = 1'b0;
    ready_d    = ready_q;
    overrun_d  = overrun_q;
    mode_d     = mode_q;
    buf_we     = 1'b0;

    if (mode_q && sample_en && xmit_state) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCapture;
          set_cnt_d = '0;
          overrun_d = 1'b0;
          mode_d    = mode;
        end
      end
      StCapture: begin
        if (sample_en) begin
          buf_we = 1'b1;
          if (set_cnt_q == LastSet) begin
            state_d    = StLoad;
            set_cnt_d  = '0;
            byte_idx_d = '0;
            rd_set_d   = '0;
            rd_ch_d    = '0;
            rd_half_d  = 1'b0;
          end else begin
            set_cnt_d = set_cnt_q + 1'b1;
          end
        end
      end
      StLoad: begin
        tx_data_d = cur_byte;
        // Header is excluded from the sum; the checksum byte itself is never summed.
        if (byte_idx_q == '0) begin
          cksum_d = '0;
        end else if (byte_idx_q != LastIdx) begin
          cksum_d = cksum_q + cur_byte;
        end
        state_d = StSend;
      end
      StSend: begin
        if (!tx_busy) begin
          tx_wr_en_d = 1'b1;
          state_d    = StWaitAck;
        end
      end
      StWaitAck: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (byte_idx_q == LastIdx) begin
            state_d = StDone;
            ready_d = 1'b1;
          end else begin
            state_d    = StLoad;
            byte_idx_d = byte_idx_q + 1'b1;
            if (byte_idx_q >= FirstPl) begin
              // Step read pointer: low byte -> high byte -> next channel -> next set.
              if (!rd_half_q) begin
                rd_half_d = 1'b1;
              end else begin
                rd_half_d = 1'b0;
                if (rd_ch_q == LastCh) begin
                  rd_ch_d  = '0;
                  rd_set_d = (rd_set_q == LastSet) ? '0 : rd_set_q + 1'b1;
                end else begin
                  rd_ch_d = rd_ch_q + 1'b1;
                end
              end
            end
          end
        end
      end
      StDone: begin
        if (!mode_q) begin
          if (!start) begin
            state_d = StIdle;
            ready_d = 1'b0;
          end
        end else begin
          ready_d = 1'b0;
          if (start) begin
            state_d   = StCapture;
            set_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= StIdle;
      set_cnt_q  <= '0;
      byte_idx_q <= '0;
      rd_set_q   <= '0;
      rd_ch_q    <= '0;
      rd_half_q  <= 1'b0;
      cksum_q    <= '0;
      tx_data_q  <= '0;
      tx_wr_en_q <= 1'b0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_cnt_q  <= set_cnt_d;
      byte_idx_q <= byte_idx_d;
      rd_set_q   <= rd_set_d;
      rd_ch_q    <= rd_ch_d;
      rd_half_q  <= rd_half_d;
      cksum_q    <= cksum_d;
      tx_data_q  <= tx_data_d;
      tx_wr_en_q <= tx_wr_en_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      mode_q     <= mode_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_wr_en = tx_wr_en_q;
  assign ready    = ready_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_adc_frame_streamer.sv
// Randomized self-checking bench for adc_frame_streamer with a uart busy model and a
// frame-level reference model (expected byte list built from the captured sample sets).
module tb_adc_frame_streamer;

  localparam int unsigned NCh      = 2;
  localparam int unsigned SampleW  = 12;
  localparam int unsigned Depth    = 4;
  localparam int unsigned FrameLen = 3 + 2 * Depth * NCh;

  logic                   sysclk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   mode;
  logic                   man_se;
  logic                   auto_se = 1'b0;
  logic                   sample_en;
  logic [NCh*SampleW-1:0] adc_data;
  logic                   tx_busy;
  logic [7:0]             tx_data;
  logic                   tx_wr_en;
  logic                   ready;
  logic                   busy;
  logic                   overrun;

  assign sample_en = man_se | auto_se;

  always #5 sysclk = ~sysclk;

  adc_frame_streamer #(
    .N_CH     (NCh),
    .SAMPLE_W (SampleW),
    .DEPTH    (Depth),
    .HDR_BYTE (8'hA5)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .sample_en (sample_en),
    .adc_data  (adc_data),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_wr_en  (tx_wr_en),
    .ready     (ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // uart model: each accepted write keeps tx_busy high for busy_len cycles.
  int         busy_len   = 10;
  int         uart_cnt   = 0;
  bit         force_busy = 1'b0;
  logic [7:0] rx_q[$];
  int         wr_pulses     = 0;
  int         wr_wide       = 0;
  int         wr_while_busy = 0;
  bit         wr_prev       = 1'b0;

  assign tx_busy = (uart_cnt != 0) || force_busy;

  always @(posedge sysclk) begin
    if (tx_wr_en) begin
      rx_q.push_back(tx_data);
      wr_pulses++;
      if (tx_busy) wr_while_busy++;
      if (wr_prev) wr_wide++;
      uart_cnt <= busy_len;
    end else if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
    end
    wr_prev <= tx_wr_en;
  end

  int ready_rises  = 0;
  int ready_cycles = 0;
  bit ready_prev   = 1'b0;

  always @(negedge sysclk) begin
    if (ready) ready_cycles++;
    if (ready && !ready_prev) ready_rises++;
    ready_prev = ready;
  end

  // Free-running strobe source for continuous mode.
  bit auto_run    = 1'b0;
  int auto_period = 20;
  int auto_cnt    = 0;

  always @(negedge sysclk) begin
    if (auto_run) begin
      auto_cnt = (auto_cnt + 1) % auto_period;
      auto_se  = (auto_cnt == 0);
    end else begin
      auto_cnt = 0;
      auto_se  = 1'b0;
    end
  end

  // Reference model: the sample sets the DUT should have captured, and the frame they imply.
  logic [15:0] exp_set [Depth][NCh];
  logic [7:0]  exp_q[$];

  task automatic build_expected();
    int unsigned sum;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(NCh));
    sum = NCh;
    for (int s = 0; s < Depth; s++) begin
      for (int c = 0; c < NCh; c++) begin
        exp_q.push_back(exp_set[s][c][7:0]);
        exp_q.push_back(exp_set[s][c][15:8]);
        sum += exp_set[s][c][7:0] + exp_set[s][c][15:8];
      end
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic check_frame(input string tag, input int base);
    check({tag, "_len"}, 32'(rx_q.size() >= base + FrameLen), 32'd1);
    for (int i = 0; i < FrameLen && base + i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_q[base + i], exp_q[i]);
    end
  endtask

  // Drives Depth strobes: kind 0 = fixed 123/ABC, 1 = ramp, else random.
  task automatic capture_frame(input int kind);
    for (int s = 0; s < Depth; s++) begin
      logic [11:0] c0;
      logic [11:0] c1;
      case (kind)
        0:       begin c0 = 12'h123;       c1 = 12'hABC; end
        1:       begin c0 = 12'(s);        c1 = 12'hFFF - 12'(s); end
        default: begin c0 = 12'($urandom); c1 = 12'($urandom); end
      endcase
      exp_set[s][0] = {4'h0, c0};
      exp_set[s][1] = {4'h0, c1};
      adc_data = {c1, c0};
      man_se = 1'b1;
      @(negedge sysclk);
      man_se = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge sysclk);
    end
  endtask

  // Waits for ready; with noise, fires random strobes with junk data meanwhile.
  task automatic wait_ready(input string tag, input bit noise, input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      if (noise && $urandom_range(0, 5) == 0) begin
        adc_data = NCh * SampleW'($urandom);
        man_se   = 1'b1;
      end else begin
        man_se = 1'b0;
      end
      @(negedge sysclk);
      n++;
    end
    man_se = 1'b0;
    check({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic single_shot(input string tag, input int kind, input int blen, input bit noise,
                             input bit do_force);
    logic [7:0] d0;
    int         p0;
    int         n;
    busy_len = blen;
    rx_q.delete();
    wr_pulses = 0;
    wr_wide = 0;
    wr_while_busy = 0;
    mode  = 1'b0;
    start = 1'b1;
    @(negedge sysclk);
    check({tag, "_busy_cap"}, 32'(busy), 32'd1);
    capture_frame(kind);
    if (do_force) begin
      n = 0;
      while (!(wr_pulses >= 5 && tx_busy && !tx_wr_en) && n < 2000) begin
        @(negedge sysclk);
        n++;
      end
      force_busy = 1'b1;
      repeat (2) @(negedge sysclk);
      d0 = tx_data;
      p0 = wr_pulses;
      repeat (48) @(negedge sysclk);
      check({tag, "_hold_data"}, tx_data, d0);
      check({tag, "_hold_wr"}, wr_pulses, p0);
      force_busy = 1'b0;
    end
    wait_ready(tag, noise, 3000);
    build_expected();
    check_frame(tag, 0);
    check({tag, "_pulses"}, wr_pulses, FrameLen);
    check({tag, "_wide"}, wr_wide, 0);
    check({tag, "_wr_busy"}, wr_while_busy, 0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
    repeat (3) @(negedge sysclk);
    check({tag, "_ready_hold"}, 32'(ready), 32'd1);
    start = 1'b0;
    repeat (2) @(negedge sysclk);
    check({tag, "_ready_clr"}, 32'(ready), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int p0;
    int frames;
    logic [11:0] k0;
    logic [11:0] k1;
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    man_se = 1'b0;
    adc_data = '0;
    repeat (3) @(negedge sysclk);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_wr_en", 32'(tx_wr_en), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    @(negedge sysclk);

    // Strobes while idle must not start anything.
    repeat (3) begin
      adc_data = NCh * SampleW'($urandom);
      man_se = 1'b1;
      @(negedge sysclk);
      man_se = 1'b0;
      @(negedge sysclk);
    end
    check("idle_se_busy", 32'(busy), 32'd0);
    check("idle_se_ovr", 32'(overrun), 32'd0);
    check("idle_se_wr", wr_pulses, 0);

    single_shot("fixed", 0, 10, 1'b0, 1'b0);
    check("fixed_cksum", rx_q[FrameLen-1], 8'hAA);
    check("fixed_b5", rx_q[5], 8'h0A);
    single_shot("ramp", 1, $urandom_range(3, 12), 1'b1, 1'b0);
    single_shot("rand0", 2, $urandom_range(3, 12), 1'b1, 1'b0);
    single_shot("rand1", 2, $urandom_range(3, 12), 1'b0, 1'b0);
    single_shot("force", 2, 6, 1'b0, 1'b1);

    // Reset in the middle of payload byte 7 (frame byte 9).
    busy_len = 8;
    rx_q.delete();
    wr_pulses = 0;
    mode = 1'b0;
    start = 1'b1;
    @(negedge sysclk);
    capture_frame(2);
    n = 0;
    while (wr_pulses < 10 && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    check("rstmid_reach", 32'(wr_pulses >= 10), 32'd1);
    repeat (2) @(negedge sysclk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge sysclk);
    rst = 1'b0;
    check("rstmid_tx_data", tx_data, 8'h00);
    check("rstmid_wr_en", 32'(tx_wr_en), 32'd0);
    check("rstmid_ready", 32'(ready), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ovr", 32'(overrun), 32'd0);
    p0 = wr_pulses;
    repeat (40) @(negedge sysclk);
    check("rstmid_quiet", wr_pulses, p0);
    single_shot("postrst", 2, 5, 1'b0, 1'b0);

    // Continuous mode with strobes faster than a frame transmit.
    busy_len = 4;
    rx_q.delete();
    wr_pulses = 0;
    wr_wide = 0;
    k0 = 12'($urandom);
    k1 = 12'($urandom);
    adc_data = {k1, k0};
    for (int s = 0; s < Depth; s++) begin
      exp_set[s][0] = {4'h0, k0};
      exp_set[s][1] = {4'h0, k1};
    end
    build_expected();
    ready_rises = 0;
    ready_cycles = 0;
    mode = 1'b1;
    start = 1'b1;
    auto_period = 20;
    auto_run = 1'b1;
    frames = 0;
    n = 0;
    while (frames < 3 && n < 6000) begin
      @(negedge sysclk);
      n++;
      if (ready) begin
        frames++;
        if (frames == 1) check("cont_ovr_first", 32'(overrun), 32'd1);
        if (frames == 3) start = 1'b0;
      end
    end
    check("cont_frames", frames, 3);
    @(negedge sysclk);
    auto_run = 1'b0;
    repeat (3) @(negedge sysclk);
    check("cont_idle", 32'(busy), 32'd0);
    check("cont_ready_low", 32'(ready), 32'd0);
    check("cont_ovr_sticky", 32'(overrun), 32'd1);
    check("cont_rises", ready_rises, 3);
    check("cont_pulse_w", ready_cycles, 3);
    check("cont_bytes", rx_q.size(), 3 * FrameLen);
    check("cont_wide", wr_wide, 0);
    for (int f = 0; f < 3; f++) begin
      check_frame($sformatf("cont_f%0d", f), f * FrameLen);
    end
    start = 1'b1;
    repeat (2) @(negedge sysclk);
    check("cont_ovr_clr", 32'(overrun), 32'd0);
    check("cont_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
